// File: rtl/servo_pkg.sv
// Shared types and default timing constants for the continuous-rotation servo PWM block.
package servo_pkg;

  localparam int CNT_W = 18;

  localparam int PERIOD_CYC_DEF = 200000;
  localparam int CENTER_CYC_DEF = 15000;
  localparam int STEP_CYC_DEF   = 50;
  localparam int MAX_SPEED_DEF  = 100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } servo_state_t;

endpackage

// File: rtl/servo_width_calc.sv
// Combinational speed saturation and pulse-width arithmetic (signed, full 18-bit).
module servo_width_calc
  import servo_pkg::*;
#(
  parameter int CENTER_CYC = CENTER_CYC_DEF,
  parameter int STEP_CYC   = STEP_CYC_DEF,
  parameter int MAX_SPEED  = MAX_SPEED_DEF
) (
  input  logic [7:0]       speed8,
  output logic [7:0]       sat_speed,
  output logic [CNT_W-1:0] width18
);

  logic signed [8:0]       speed_s;
  logic signed [8:0]       max_pos;
  logic signed [8:0]       max_neg;
  logic signed [8:0]       sat_s;
  logic signed [CNT_W-1:0] sat_ext;
  logic signed [CNT_W-1:0] center_s;
  logic signed [CNT_W-1:0] step_s;
  logic signed [CNT_W-1:0] width_s;

  always_comb begin
    speed_s = $signed({speed8[7], speed8});
    max_pos = MAX_SPEED[8:0];
    max_neg = -max_pos;
    if (speed_s > max_pos) begin
      sat_s = max_pos;
    end else if (speed_s < max_neg) begin
      sat_s = max_neg;
    end else begin
      sat_s = speed_s;
    end
  end

  // Widen before multiplying so the product never loses its sign or upper bits.
  always_comb begin
    sat_ext  = {{(CNT_W-9){sat_s[8]}}, sat_s};
    center_s = CENTER_CYC[CNT_W-1:0];
    step_s   = STEP_CYC[CNT_W-1:0];
    width_s  = center_s + sat_ext * step_s;
  end

  assign sat_speed = sat_s[7:0];
  assign width18   = width_s;

endmodule

// File: rtl/cont_servo_pwm.sv
// Continuous-rotation servo PWM: command handshake, frame FSM and frame counter.
//   state   | meaning
//   IDLE    | output low, counter parked at 0, waiting for enable
//   HIGH    | pulse portion of the frame, pwm_out=1
//   LOW     | remainder of the frame, pwm_out=0
module cont_servo_pwm
  import servo_pkg::*;
#(
  parameter int PERIOD_CYC = PERIOD_CYC_DEF,
  parameter int CENTER_CYC = CENTER_CYC_DEF,
  parameter int STEP_CYC   = STEP_CYC_DEF,
  parameter int MAX_SPEED  = MAX_SPEED_DEF
) (
  input  logic       SYSCLK,
  input  logic       NSYSRESET,
  input  logic       enable,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_speed,
  output logic       cmd_ready,
  output logic       pwm_out,
  output logic       frame_start,
  output logic [7:0] active_speed
);

  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(PERIOD_CYC - 1);
  localparam logic [CNT_W-1:0] CENTER_W    = CNT_W'(CENTER_CYC);

  servo_state_t     state_q;
  servo_state_t     state_nxt;
  logic             frame_load;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] width_q;
  logic [CNT_W-1:0] width_last;
  logic [CNT_W-1:0] width_calc;
  logic [7:0]       shadow_q;
  logic [7:0]       shadow_nxt;
  logic [7:0]       active_q;
  logic [7:0]       sat_calc;
  logic             accept;

  assign accept     = cmd_valid & cmd_ready;
  // A command taken on the last cycle of a frame still reaches the next frame.
  assign shadow_nxt = accept ? cmd_speed : shadow_q;
  assign width_last = width_q - 1'b1;

  servo_width_calc #(
    .CENTER_CYC(CENTER_CYC),
    .STEP_CYC  (STEP_CYC),
    .MAX_SPEED (MAX_SPEED)
  ) u_width_calc (
    .speed8   (shadow_nxt),
    .sat_speed(sat_calc),
    .width18  (width_calc)
  );

  always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
    if (!NSYSRESET) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state_q;
    frame_load = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_nxt  = ST_HIGH;
          frame_load = 1'b1;
        end
      end
      ST_HIGH: begin
        if (cnt_q == width_last) begin
          state_nxt = ST_LOW;
        end
      end
      ST_LOW: begin
        if (cnt_q == PERIOD_LAST) begin
          if (enable) begin
            state_nxt  = ST_HIGH;
            frame_load = 1'b1;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
    if (!NSYSRESET) begin
      cnt_q <= '0;
    end else if (frame_load || (state_nxt == ST_IDLE)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
    if (!NSYSRESET) begin
      shadow_q <= '0;
      active_q <= '0;
      width_q  <= CENTER_W;
    end else begin
      shadow_q <= shadow_nxt;
      if (frame_load) begin
        active_q <= sat_calc;
        width_q  <= width_calc;
      end
    end
  end

  assign pwm_out      = (state_q == ST_HIGH);
  assign frame_start  = (state_q == ST_HIGH) && (cnt_q == '0);
  assign cmd_ready    = ~frame_start;
  assign active_speed = active_q;

endmodule

// File: tb/tb_cont_servo_pwm.sv
// Self-checking bench for cont_servo_pwm using shortened frame timing.
module tb_cont_servo_pwm;

  localparam int PERIOD = 500;
  localparam int CENTER = 210;
  localparam int STEP   = 2;
  localparam int MAXS   = 100;

  typedef struct {
    int         width;
    logic [7:0] spd;
  } exp_t;

  typedef struct {
    logic [7:0] cmd;
    int         width;
    logic [7:0] spd;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       cmd_valid;
  logic [7:0] cmd_speed;
  logic       cmd_ready;
  logic       pwm_out;
  logic       frame_start;
  logic [7:0] active_speed;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  int         hi_cnt = 0;
  int         cyc = 0;
  int         last_fs = 0;
  bit         fs_valid = 1'b0;
  int         ready_bad = 0;
  logic [7:0] act_cap = 8'd0;

  cont_servo_pwm #(
    .PERIOD_CYC(PERIOD),
    .CENTER_CYC(CENTER),
    .STEP_CYC  (STEP),
    .MAX_SPEED (MAXS)
  ) dut (
    .SYSCLK      (clk),
    .NSYSRESET   (rst_n),
    .enable      (enable),
    .cmd_valid   (cmd_valid),
    .cmd_speed   (cmd_speed),
    .cmd_ready   (cmd_ready),
    .pwm_out     (pwm_out),
    .frame_start (frame_start),
    .active_speed(active_speed)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Pulse monitor: measures each high phase and frame spacing, compares against scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      hi_cnt   = 0;
      fs_valid = 1'b0;
    end else begin
      if (cmd_ready !== !frame_start) ready_bad++;
      if (frame_start) begin
        act_cap = active_speed;
        if (fs_valid) check("frame_len", cyc - last_fs, PERIOD);
        fs_valid = 1'b1;
        last_fs  = cyc;
      end
      if (!enable) fs_valid = 1'b0;
      if (pwm_out) begin
        hi_cnt++;
      end else if (hi_cnt != 0) begin
        if (sb_q.size() == 0) begin
          check("unexpected_pulse", hi_cnt, 0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("pulse_width", hi_cnt, e.width);
          check("active_speed", $signed(act_cap), $signed(e.spd));
        end
        hi_cnt = 0;
      end
    end
    cyc++;
  end

  task automatic push(input int w, input logic [7:0] s);
    exp_t e;
    e.width = w;
    e.spd   = s;
    sb_q.push_back(e);
  endtask

  task automatic wait_fs();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_start && n < 2 * PERIOD + 10);
    if (!frame_start) check("frame_start_timeout", 0, 1);
  endtask

  task automatic send(input logic [7:0] s);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_speed = s;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  vec_t vecs[9];

  initial begin
    int fs_seen;
    int hi_seen;

    vecs[0] = '{8'd100,  CENTER + 100*STEP, 8'd100};
    vecs[1] = '{8'd127,  CENTER + 100*STEP, 8'd100};
    vecs[2] = '{8'h80,   CENTER - 100*STEP, 8'h9C};
    vecs[3] = '{8'h9C,   CENTER - 100*STEP, 8'h9C};
    vecs[4] = '{8'h9B,   CENTER - 100*STEP, 8'h9C};
    vecs[5] = '{8'd50,   CENTER + 50*STEP,  8'd50};
    vecs[6] = '{8'hFF,   CENTER - STEP,     8'hFF};
    vecs[7] = '{8'd101,  CENTER + 100*STEP, 8'd100};
    vecs[8] = '{8'd0,    CENTER,            8'd0};

    rst_n     = 1'b0;
    enable    = 1'b0;
    cmd_valid = 1'b0;
    cmd_speed = 8'd0;
    repeat (3) @(negedge clk);
    check("rst_pwm", int'(pwm_out), 0);
    check("rst_frame_start", int'(frame_start), 0);
    check("rst_cmd_ready", int'(cmd_ready), 1);
    check("rst_active_speed", int'(active_speed), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // First frame starts one cycle after enable, carrying speed 0.
    enable = 1'b1;
    push(CENTER, 8'd0);
    @(negedge clk);
    check("fs_latency", int'(frame_start), 1);

    for (int i = 0; i < 9; i++) begin
      repeat (10) @(negedge clk);
      send(vecs[i].cmd);
      push(vecs[i].width, vecs[i].spd);
      wait_fs();
    end
    repeat (CENTER + 100*STEP + 10) @(negedge clk);
    check("table_drained", sb_q.size(), 0);

    // Last writer wins within one frame.
    send(8'd10);
    send(8'd20);
    send(8'd30);
    push(CENTER + 30*STEP, 8'd30);
    wait_fs();
    repeat (CENTER + 30*STEP + 10) @(negedge clk);
    check("lww_drained", sb_q.size(), 0);

    // Enable dropped during the pulse: pulse and frame complete, then silence.
    push(CENTER + 30*STEP, 8'd30);
    wait_fs();
    repeat (50) @(negedge clk);
    enable = 1'b0;
    repeat (CENTER + 30*STEP) @(negedge clk);
    fs_seen = 0;
    hi_seen = 0;
    for (int i = 0; i < 3 * PERIOD; i++) begin
      @(negedge clk);
      if (frame_start) fs_seen++;
      if (pwm_out) hi_seen++;
    end
    check("idle_no_frame_start", fs_seen, 0);
    check("idle_pwm_low", hi_seen, 0);
    check("drop_drained", sb_q.size(), 0);

    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    check("reenable_fs_latency", int'(frame_start), 1);
    check("reenable_speed", int'(active_speed), 30);

    // Reset in the middle of the pulse forces outputs at once.
    repeat (70) @(negedge clk);
    check("pre_reset_pwm", int'(pwm_out), 1);
    #2;
    rst_n  = 1'b0;
    enable = 1'b0;
    #1;
    check("async_rst_pwm", int'(pwm_out), 0);
    check("async_rst_frame_start", int'(frame_start), 0);
    check("async_rst_cmd_ready", int'(cmd_ready), 1);
    check("async_rst_active_speed", int'(active_speed), 0);
    repeat (3) @(negedge clk);
    check("held_rst_pwm", int'(pwm_out), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Shadow was cleared by reset, so the next frame runs at center width.
    enable = 1'b1;
    push(CENTER, 8'd0);
    wait_fs();
    check("post_rst_speed", int'(active_speed), 0);
    repeat (CENTER + 10) @(negedge clk);
    check("final_drained", sb_q.size(), 0);
    check("ready_only_low_on_fs", ready_bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
